cnn_frame_sequencer: RTL

- Frame-level sequencer that feeds the CNN_net pixel front end.
- On command, it reads one grey-scale frame from a ping-pong frame buffer and replays it as a pre_vsync/pre_href/pre_data stream with programmed blanking.
- It tracks bank ownership so an upstream writer can fill one bank while the other is streamed.
- It supports single-shot or continuous operation and reports completion to the host/test logic.

---
 rtl/cnn_frame_sequencer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/cnn_frame_sequencer.sv
// cnn_frame_sequencer: replays one bank of a ping-pong frame buffer as a
// pre_vsync/pre_href/pre_data stream with programmed front, row and frame blanking.
module cnn_frame_sequencer #(
    parameter int unsigned IMG_W       = 64,
    parameter int unsigned IMG_H       = 64,
    parameter int unsigned FRONT_BLANK = 10,
    parameter int unsigned H_GAP       = 10,
    parameter int unsigned FRAME_GAP   = 1000,
    parameter int unsigned RD_LAT      = 1,
    parameter int unsigned ADDR_W      = $clog2(IMG_W * IMG_H)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cont,
    input  logic              abort,
    input  logic              wr_bank_ready,
    output logic              rd_en,
    output logic [ADDR_W:0]   rd_addr,
    input  logic [7:0]        rd_data,
    output logic              pre_vsync,
    output logic              pre_href,
    output logic [7:0]        pre_data,
    output logic              busy,
    output logic              done,
    output logic              rd_bank,
    output logic [15:0]       frame_cnt
);

    function automatic int unsigned umax(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned LEAD  = RD_LAT + 1;
    localparam int unsigned NPIX  = IMG_W * IMG_H;
    localparam int unsigned CMAX  = umax(umax(FRONT_BLANK, H_GAP), umax(IMG_W, FRAME_GAP));
    localparam int unsigned CW    = $clog2(CMAX + 1);
    localparam int unsigned RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    // Read window per row: the last LEAD cycles of GAP plus the ACTIVE cycles
    // that still have a pixel LEAD cycles ahead of them.
    localparam int unsigned GAP_RD_FIRST_I = H_GAP - LEAD;
    localparam int unsigned GAP_RD_END_I   = (IMG_W >= LEAD) ? H_GAP : (H_GAP - LEAD + IMG_W);
    localparam int unsigned ACT_RD_END_I   = (IMG_W > LEAD) ? (IMG_W - LEAD) : 0;

    localparam logic [CW-1:0]     FRONT_LAST   = CW'(FRONT_BLANK - 1);
    localparam logic [CW-1:0]     GAP_LAST     = CW'(H_GAP - 1);
    localparam logic [CW-1:0]     ACT_LAST     = CW'(IMG_W - 1);
    localparam logic [CW-1:0]     WAIT_LAST    = CW'(FRAME_GAP - 1);
    localparam logic [CW-1:0]     GAP_RD_FIRST = CW'(GAP_RD_FIRST_I);
    localparam logic [CW-1:0]     GAP_RD_END   = CW'(GAP_RD_END_I);
    localparam logic [CW-1:0]     ACT_RD_END   = CW'(ACT_RD_END_I);
    localparam logic [RW-1:0]     ROW_LAST     = RW'(IMG_H - 1);
    localparam logic [ADDR_W-1:0] PTR_LAST     = ADDR_W'(NPIX - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FRONT,
        S_GAP,
        S_ACTIVE,
        S_END,
        S_WAIT
    } state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [RW-1:0]     row, row_nxt;
    logic [ADDR_W-1:0] rd_ptr;
    logic              end_cont;
    logic              frame_start;
    logic              rd_issue;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CW'(1);
        row_nxt   = row;
        if (abort && state != S_IDLE) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    cnt_nxt = '0;
                    if (start && !abort) state_nxt = S_FRONT;
                end
                S_FRONT: begin
                    if (cnt == FRONT_LAST) begin
                        state_nxt = S_GAP;
                        cnt_nxt   = '0;
                    end
                end
                S_GAP: begin
                    if (cnt == GAP_LAST) begin
                        state_nxt = S_ACTIVE;
                        cnt_nxt   = '0;
                    end
                end
                S_ACTIVE: begin
                    if (cnt == ACT_LAST) begin
                        cnt_nxt = '0;
                        if (row == ROW_LAST) begin
                            state_nxt = S_END;
                        end else begin
                            state_nxt = S_GAP;
                            row_nxt   = row + RW'(1);
                        end
                    end
                end
                S_END: begin
                    cnt_nxt   = '0;
                    state_nxt = end_cont ? S_WAIT : S_IDLE;
                end
                S_WAIT: begin
                    if (!cont) begin
                        state_nxt = S_IDLE;
                        cnt_nxt   = '0;
                    end else if (cnt == WAIT_LAST) begin
                        state_nxt = S_FRONT;
                        cnt_nxt   = '0;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end

        frame_start = (state_nxt == S_FRONT) && (state != S_FRONT);
        if (frame_start) row_nxt = '0;

        // Outputs are registered, so they are decoded from the upcoming state.
        rd_issue = 1'b0;
        if (state_nxt == S_GAP)
            rd_issue = (cnt_nxt >= GAP_RD_FIRST) && (cnt_nxt < GAP_RD_END);
        else if (state_nxt == S_ACTIVE)
            rd_issue = (cnt_nxt < ACT_RD_END);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            row       <= '0;
            rd_ptr    <= '0;
            end_cont  <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            pre_vsync <= 1'b0;
            pre_href  <= 1'b0;
            pre_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_bank   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            row       <= row_nxt;
            pre_vsync <= (state_nxt == S_GAP) || (state_nxt == S_ACTIVE);
            pre_href  <= (state_nxt == S_ACTIVE);
            done      <= (state_nxt == S_END);
            rd_en     <= rd_issue;

            if (state_nxt == S_ACTIVE) pre_data <= rd_data;

            // busy in the END cycle already reflects whether the frame chain continues.
            if (state_nxt == S_END) begin
                busy      <= cont;
                end_cont  <= cont;
                frame_cnt <= frame_cnt + 16'd1;
            end else begin
                busy <= (state_nxt != S_IDLE);
            end

            if (frame_start) begin
                rd_ptr <= '0;
            end else if (rd_issue) begin
                rd_addr <= {rd_bank, rd_ptr};
                rd_ptr  <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + ADDR_W'(1);
            end

            if (state == S_END && !abort && wr_bank_ready) rd_bank <= ~rd_bank;
        end
    end

endmodule
